// File: rtl/comp_arbiter.sv
// Two-port round-robin sequencer for the shared 4-bit equality comparator.
// Issues one compare at a time, waits the comparator latency and returns the result.
module comp_arbiter #(
  parameter int COMP_LAT = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_exp,
  input  logic [3:0]       req0_val,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp0_eq,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_exp,
  input  logic [3:0]       req1_val,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic             rsp1_eq,
  output logic             comp_en,
  output logic [3:0]       comp_exp,
  output logic [3:0]       comp_alu,
  input  logic             comp_result,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_L = 3'(COMP_LAT);

  state_t           state, state_nxt;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic             grant_vld;
  logic             req_hs;
  logic             rsp_hs;
  logic             wait_last;
  logic [2:0]       wait_cnt;
  logic             rsp_eq_q;
  logic [3:0]       exp_q;
  logic [3:0]       alu_q;
  logic [CNT_W-1:0] match_q;
  logic [CNT_W-1:0] miss_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Arbitration: a tie goes to the port that did not win last time
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  assign req0_ready = (state == IDLE) && grant_vld && !grant;
  assign req1_ready = (state == IDLE) && grant_vld &&  grant;
  assign req_hs     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_hs     = owner ? rsp1_ready : rsp0_ready;
  assign wait_last  = (wait_cnt == 3'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_hs)    state_nxt = ISSUE;
      ISSUE:                  state_nxt = WAIT;
      WAIT:    if (wait_last) state_nxt = RESP;
      RESP:    if (rsp_hs)    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wait_cnt   <= 3'd0;
      rsp_eq_q   <= 1'b0;
      exp_q      <= 4'd0;
      alu_q      <= 4'd0;
      match_q    <= '0;
      miss_q     <= '0;
    end else begin
      state <= state_nxt;
      // Accept: capture operands so later requester changes cannot disturb the compare
      if (state == IDLE && req_hs) begin
        owner      <= grant;
        last_grant <= grant;
        exp_q      <= grant ? req1_exp : req0_exp;
        alu_q      <= grant ? req1_val : req0_val;
      end
      if (state == ISSUE)     wait_cnt <= LAT_L;
      else if (state == WAIT) wait_cnt <= wait_cnt - 3'd1;
      // Result capture on the final wait cycle, when the comparator output is valid
      if (state == WAIT && wait_last) begin
        rsp_eq_q <= comp_result;
        if (comp_result) match_q <= sat_inc(match_q);
        else             miss_q  <= sat_inc(miss_q);
      end
    end
  end

  assign comp_en    = (state == ISSUE);
  assign comp_exp   = exp_q;
  assign comp_alu   = alu_q;
  assign busy       = (state != IDLE);
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;
  assign rsp0_eq    = rsp_eq_q && !owner;
  assign rsp1_eq    = rsp_eq_q &&  owner;
  assign match_cnt  = match_q;
  assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_comp_arbiter.sv
// Bench for comp_arbiter: default instance plus a COMP_LAT=3 / CNT_W=2 instance,
// each driven against a behavioural registered comparator.
module tb_comp_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic       rst_n;
  logic [1:0] req_valid;
  logic [3:0] req_exp [2];
  logic [3:0] req_val [2];
  logic [1:0] rsp_ready;
  wire  [1:0] req_ready;
  wire  [1:0] rsp_valid;
  wire  [1:0] rsp_eq;
  wire        comp_en;
  wire  [3:0] comp_exp;
  wire  [3:0] comp_alu;
  logic       comp_result = 1'b0;
  wire        busy;
  wire  [7:0] match_cnt;
  wire  [7:0] miss_cnt;

  comp_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_exp(req_exp[0]), .req0_val(req_val[0]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_eq(rsp_eq[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_exp(req_exp[1]), .req1_val(req_val[1]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_eq(rsp_eq[1]),
    .comp_en(comp_en), .comp_exp(comp_exp), .comp_alu(comp_alu), .comp_result(comp_result),
    .busy(busy), .match_cnt(match_cnt), .miss_cnt(miss_cnt)
  );

  // Comparator model: result is registered COMP_LAT cycles after the enable edge
  always @(posedge clk) comp_result <= comp_en && (comp_exp == comp_alu);

  logic       d2_valid;
  logic [3:0] d2_exp, d2_val;
  wire        d2_ready, d2_rsp_valid, d2_rsp_eq;
  wire        d2_req1_ready, d2_rsp1_valid, d2_rsp1_eq;
  wire        d2_en, d2_busy;
  wire  [3:0] d2_cexp, d2_calu;
  wire  [1:0] d2_match, d2_miss;
  logic [2:0] d2_pipe = 3'b000;

  comp_arbiter #(.COMP_LAT(3), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(d2_valid), .req0_ready(d2_ready), .req0_exp(d2_exp), .req0_val(d2_val),
    .rsp0_valid(d2_rsp_valid), .rsp0_ready(1'b1), .rsp0_eq(d2_rsp_eq),
    .req1_valid(1'b0), .req1_ready(d2_req1_ready), .req1_exp(4'h0), .req1_val(4'h0),
    .rsp1_valid(d2_rsp1_valid), .rsp1_ready(1'b1), .rsp1_eq(d2_rsp1_eq),
    .comp_en(d2_en), .comp_exp(d2_cexp), .comp_alu(d2_calu), .comp_result(d2_pipe[2]),
    .busy(d2_busy), .match_cnt(d2_match), .miss_cnt(d2_miss)
  );

  always @(posedge clk) d2_pipe <= {d2_pipe[1:0], d2_en && (d2_cexp == d2_calu)};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entries are {port, expected eq}
  logic [1:0] sb [$];
  int exp_match = 0;
  int exp_miss  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      chk("one_ready", int'(req_ready == 2'b11), 0);
      chk("one_rsp_valid", int'(rsp_valid == 2'b11), 0);
      chk("en_implies_busy", int'(comp_en && !busy), 0);
      for (int p = 0; p < 2; p++)
        if (req_valid[p] && req_ready[p])
          sb.push_back({p[0], req_exp[p] == req_val[p]});
      for (int p = 0; p < 2; p++)
        if (rsp_valid[p] && rsp_ready[p]) begin
          if (sb.size() == 0) chk("sb_unexpected_rsp", 1, 0);
          else begin
            logic [1:0] e;
            e = sb.pop_front();
            chk("sb_port", p, int'(e[1]));
            chk("sb_eq", int'(rsp_eq[p]), int'(e[0]));
          end
        end
    end
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_eq"}, int'(rsp_eq), 0);
    chk({tag, "_comp_en"}, int'(comp_en), 0);
    chk({tag, "_comp_exp"}, int'(comp_exp), 0);
    chk({tag, "_comp_alu"}, int'(comp_alu), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_match"}, int'(match_cnt), 0);
    chk({tag, "_miss"}, int'(miss_cnt), 0);
  endtask

  // Presents a request and returns the handshake cycle; operands are scrambled afterwards
  task automatic do_req(input int p, input logic [3:0] e, input logic [3:0] v, output int a);
    int n;
    @(posedge clk); #1;
    req_valid[p] = 1'b1; req_exp[p] = e; req_val[p] = v;
    n = 0;
    @(negedge clk);
    while (!req_ready[p] && n < 50) begin @(negedge clk); n++; end
    chk("req_handshake", int'(req_ready[p]), 1);
    a = cyc;
    @(posedge clk); #1;
    req_valid[p] = 1'b0; req_exp[p] = ~e; req_val[p] = v + 4'd1;
  endtask

  // Called in cycle a+1; follows ISSUE/WAIT and checks the response with default latency
  task automatic wait_rsp(input int p, input int a, input logic [3:0] e, input logic [3:0] v,
                          input logic eq_exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[p] && n < 50) begin
      chk("comp_en_window", int'(comp_en), int'(cyc == a + 1));
      chk("comp_exp_held", int'(comp_exp), int'(e));
      chk("comp_alu_held", int'(comp_alu), int'(v));
      chk("other_rsp_quiet", int'(rsp_valid[1-p]), 0);
      @(negedge clk); n++;
    end
    chk("rsp_seen", int'(rsp_valid[p]), 1);
    chk("rsp_latency", cyc - a, 3);
    chk("rsp_eq", int'(rsp_eq[p]), int'(eq_exp));
    if (eq_exp) exp_match++; else exp_miss++;
    chk("match_cnt", int'(match_cnt), exp_match);
    chk("miss_cnt", int'(miss_cnt), exp_miss);
  endtask

  typedef struct {
    int         port;
    logic [3:0] e;
    logic [3:0] v;
    logic       eq;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int a, prev, n;
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, prev, n;
    tbl[0] = '{0, 4'hA, 4'hA, 1'b1};
    tbl[1] = '{1, 4'hA, 4'hB, 1'b0};
    tbl[2] = '{0, 4'h0, 4'h0, 1'b1};
    tbl[3] = '{1, 4'hF, 4'h0, 1'b0};
    tbl[4] = '{1, 4'h5, 4'h5, 1'b1};
    tbl[5] = '{0, 4'h3, 4'hC, 1'b0};
    tbl[6] = '{0, 4'hF, 4'hF, 1'b1};
    tbl[7] = '{1, 4'h7, 4'h6, 1'b0};

    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
    req_exp[0] = 4'h0; req_exp[1] = 4'h0; req_val[0] = 4'h0; req_val[1] = 4'h0;
    d2_valid = 1'b0; d2_exp = 4'h0; d2_val = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("reset");
    chk("reset_d2_match", int'(d2_match), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single-port transactions from the vector table, issued back to back
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      do_req(tbl[i].port, tbl[i].e, tbl[i].v, a);
      if (i > 0) chk("b2b_period", a - prev, 4);
      prev = a;
      wait_rsp(tbl[i].port, a, tbl[i].e, tbl[i].v, tbl[i].eq);
    end

    // Round-robin: both ports held valid, grants must alternate starting at port 0
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; exp_match = 0; exp_miss = 0;
    req_exp[0] = 4'h0; req_val[0] = 4'h0; req_exp[1] = 4'hF; req_val[1] = 4'h0;
    req_valid = 2'b11;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && n < 20) begin @(negedge clk); n++; end
      chk("tie_grant", int'(req_ready), (k % 2 == 0) ? 1 : 2);
      if (k > 0) chk("tie_period", cyc - prev, 4);
      prev = cyc;
      if (req_ready[0]) exp_match++; else exp_miss++;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("tie_match", int'(match_cnt), exp_match);
    chk("tie_miss", int'(miss_cnt), exp_miss);

    // Stalled response: port 1 must stay locked out until port 0 consumes
    rsp_ready = 2'b10;
    do_req(0, 4'h5, 4'h5, a);
    req_valid[1] = 1'b1; req_exp[1] = 4'h3; req_val[1] = 4'h4;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[0] && n < 20) begin
      chk("stall_pre_ready1", int'(req_ready[1]), 0);
      @(negedge clk); n++;
    end
    chk("stall_rsp_seen", int'(rsp_valid[0]), 1);
    exp_match++;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", int'(rsp_valid[0]), 1);
      chk("stall_eq", int'(rsp_eq[0]), 1);
      chk("stall_ready1", int'(req_ready[1]), 0);
      chk("stall_busy", int'(busy), 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("release_ready1_resp", int'(req_ready[1]), 0);
    chk("release_match", int'(match_cnt), exp_match);
    @(negedge clk);
    chk("release_grant1", int'(req_ready[1]), 1);
    a = cyc;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(1, a, 4'h3, 4'h4, 1'b0);

    // Reset during WAIT drops the in-flight compare
    do_req(0, 4'h7, 4'h7, a);
    @(posedge clk); #1;
    chk("prerst_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_rst("midrst");
    rst_n = 1'b1; exp_match = 0; exp_miss = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_no_rsp", int'(rsp_valid), 0);
      chk("postrst_match", int'(match_cnt), 0);
    end
    do_req(0, 4'h2, 4'h2, a);
    wait_rsp(0, a, 4'h2, 4'h2, 1'b1);

    // COMP_LAT=3, CNT_W=2 instance: latency A+5 and counter saturation at 3
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      d2_valid = 1'b1; d2_exp = 4'(k); d2_val = 4'(k);
      n = 0;
      @(negedge clk);
      while (!d2_ready && n < 20) begin @(negedge clk); n++; end
      chk("d2_handshake", int'(d2_ready), 1);
      a = cyc;
      @(posedge clk); #1;
      d2_valid = 1'b0; d2_exp = 4'hF; d2_val = 4'h0;
      n = 0;
      @(negedge clk);
      while (!d2_rsp_valid && n < 30) begin @(negedge clk); n++; end
      chk("d2_latency", cyc - a, 5);
      chk("d2_eq", int'(d2_rsp_eq), 1);
      chk("d2_match_sat", int'(d2_match), (k > 3) ? 3 : k);
      chk("d2_miss", int'(d2_miss), 0);
      chk("d2_busy", int'(d2_busy), 1);
      chk("d2_port1_quiet", int'({d2_req1_ready, d2_rsp1_valid, d2_rsp1_eq}), 0);
    end

    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
